instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction memory: owns the PC, drives the byte address, captures

---
 rtl/instruction_fetch_unit_pkg.sv | 28 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 100 ++++++++++
 rtl/instruction_fetch_unit.sv | 90 +++++++++
 tb/tb_instruction_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
//  - pc_step:    PC increment per captured word (one word = byte_w bytes)
//  - instr_w:    instruction word width in bits
//  - entry_w:    width of one prefetch entry {instruction, pc}
//  - align_low:  low-address bits cleared on a redirect (byte_w is a power of two)
package instruction_fetch_unit_pkg;

    localparam int unsigned BYTE_W_DEFAULT = 4;
    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 2;

    function automatic int unsigned pc_step(input int unsigned byte_w);
        return byte_w;
    endfunction

    function automatic int unsigned instr_w(input int unsigned byte_w);
        return 8 * byte_w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned byte_w, input int unsigned addr_w);
        return 8 * byte_w + addr_w;
    endfunction

    function automatic int unsigned align_low(input int unsigned byte_w);
        return byte_w - 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Prefetch FIFO for fetched words: stores {instruction, pc} entries.
// Ports:
//  clk, reset      clock, synchronous active-high reset
//  push, push_*    enqueue one entry (accepted when not full, or when popping)
//  pop             dequeue head (ignored when empty)
//  flush           discard all entries; overrides push/pop
//  valid, head_*   head entry; head data zeroed when empty
//  level, full     registered occupancy and its full decode
module instruction_fetch_unit_fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned BYTE_W = BYTE_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    localparam int unsigned DATA_W = instr_w(BYTE_W),
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_pc,
    output logic [LVL_W-1:0]  level,
    output logic              full
);

    localparam int unsigned ENTRY_W = entry_w(BYTE_W, ADDR_W);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;
    logic [ENTRY_W-1:0] head_entry;

    // Circular pointer advance; wraps at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid      = (count_q != '0);
    assign full       = (count_q == LVL_W'(DEPTH));
    assign level      = count_q;
    assign head_entry = mem_q[rd_ptr_q];
    assign head_data  = valid ? head_entry[ENTRY_W-1:ADDR_W] : '0;
    assign head_pc    = valid ? head_entry[ADDR_W-1:0] : '0;

    // Next-state: flush wins; a push into a full FIFO only lands if the head leaves this edge.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop & valid;
        do_push  = push & (~full | do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = {push_data, push_pc};
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses instruction memory, captures
// each returned word with its PC into a prefetch FIFO and presents the head to
// decode over valid/ready. A taken branch flushes the FIFO and reloads the PC.
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  inp_fetch_enable      allow captures / PC advance
//  out_imem_address      byte address to instruction memory (= PC register)
//  inp_imem_data         word returned for out_imem_address, same cycle
//  inp_branch_taken      redirect request; inp_branch_target is its byte address
//  out_valid, inp_ready  decode handshake on the FIFO head
//  out_instruction       head word (0 when empty)
//  out_pc                head byte address (0 when empty)
//  out_level             FIFO occupancy
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned byte_W   = BYTE_W_DEFAULT,
    parameter int unsigned Addr_W   = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT,
    parameter logic [Addr_W-1:0] RESET_PC = '0,
    localparam int unsigned INSTR_W = instr_w(byte_W),
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_fetch_enable,
    output logic [Addr_W-1:0]  out_imem_address,
    input  logic [INSTR_W-1:0] inp_imem_data,
    input  logic               inp_branch_taken,
    input  logic [Addr_W-1:0]  inp_branch_target,
    output logic               out_valid,
    input  logic               inp_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [Addr_W-1:0]  out_pc,
    output logic [LVL_W-1:0]   out_level
);

    localparam logic [Addr_W-1:0] PC_STEP    = Addr_W'(pc_step(byte_W));
    localparam logic [Addr_W-1:0] ALIGN_MASK = ~Addr_W'(align_low(byte_W));

    logic [Addr_W-1:0] pc_q, pc_d;
    logic              capture;
    logic              pop;
    logic              fifo_valid;
    logic              fifo_full;

    assign out_imem_address = pc_q;
    assign out_valid        = fifo_valid;

    // Redirect takes precedence over fetch and drain; otherwise capture whenever a slot is free
    // now or is being freed by this edge's pop.
    always_comb begin
        pop     = fifo_valid & inp_ready & ~inp_branch_taken;
        capture = inp_fetch_enable & ~inp_branch_taken & (~fifo_full | pop);
        pc_d    = pc_q;
        if (inp_branch_taken) begin
            pc_d = inp_branch_target & ALIGN_MASK;
        end else if (capture) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    instruction_fetch_unit_fetch_fifo #(
        .BYTE_W (byte_W),
        .ADDR_W (Addr_W),
        .DEPTH  (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (inp_imem_data),
        .push_pc   (pc_q),
        .pop       (pop),
        .flush     (inp_branch_taken),
        .valid     (fifo_valid),
        .head_data (out_instruction),
        .head_pc   (out_pc),
        .level     (out_level),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench: two fetch units (RESET_PC 0x00 and 0xFC) share one stimulus stream and one
// word-addressed instruction memory. A queue-style reference model predicts every output
// each cycle; directed literal checks pin the expected sequences.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        br  = 1'b0;
    logic [7:0]  tgt = 8'h00;
    logic        rdy = 1'b0;

    logic [31:0] mem [64];

    logic [7:0]  addr   [2];
    logic [31:0] idata  [2];
    logic        valid  [2];
    logic [31:0] instr  [2];
    logic [7:0]  opc    [2];
    logic [1:0]  level  [2];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: ordered list of {instr, pc} per DUT, plus the PC.
    logic [7:0]  m_pc   [2];
    logic [31:0] m_ins  [2][DEPTH];
    logic [7:0]  m_pcs  [2][DEPTH];
    int          m_cnt  [2];
    logic [7:0]  rst_pc [2];

    always #5 clk = ~clk;

    assign idata[0] = mem[addr[0][7:2]];
    assign idata[1] = mem[addr[1][7:2]];

    instruction_fetch_unit #(.byte_W(4), .Addr_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut0 (
        .clk(clk), .reset(rst), .inp_fetch_enable(en), .out_imem_address(addr[0]),
        .inp_imem_data(idata[0]), .inp_branch_taken(br), .inp_branch_target(tgt),
        .out_valid(valid[0]), .inp_ready(rdy), .out_instruction(instr[0]),
        .out_pc(opc[0]), .out_level(level[0])
    );

    instruction_fetch_unit #(.byte_W(4), .Addr_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFC)) u_dut1 (
        .clk(clk), .reset(rst), .inp_fetch_enable(en), .out_imem_address(addr[1]),
        .inp_imem_data(idata[1]), .inp_branch_taken(br), .inp_branch_target(tgt),
        .out_valid(valid[1]), .inp_ready(rdy), .out_instruction(instr[1]),
        .out_pc(opc[1]), .out_level(level[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_edge(input int k);
        bit pop, push;
        if (rst) begin
            m_pc[k]  = rst_pc[k];
            m_cnt[k] = 0;
        end else if (br) begin
            m_cnt[k] = 0;
            m_pc[k]  = tgt & 8'hFC;
        end else begin
            pop  = (m_cnt[k] > 0) && rdy;
            push = en && ((m_cnt[k] < DEPTH) || pop);
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    m_ins[k][i] = m_ins[k][i+1];
                    m_pcs[k][i] = m_pcs[k][i+1];
                end
                m_cnt[k]--;
            end
            if (push) begin
                m_ins[k][m_cnt[k]] = mem[m_pc[k][7:2]];
                m_pcs[k][m_cnt[k]] = m_pc[k];
                m_cnt[k]++;
                m_pc[k] = m_pc[k] + 8'd4;
            end
        end
    endtask

    // One cycle: wait for the edge, update model, compare every output of both DUTs.
    task automatic step();
        @(posedge clk);
        #1;
        vectors++;
        for (int k = 0; k < 2; k++) begin
            model_edge(k);
            chk($sformatf("addr%0d", k), 32'(addr[k]), 32'(m_pc[k]));
            chk($sformatf("valid%0d", k), 32'(valid[k]), 32'(m_cnt[k] > 0));
            chk($sformatf("level%0d", k), 32'(level[k]), 32'(m_cnt[k]));
            chk($sformatf("instr%0d", k), instr[k], (m_cnt[k] > 0) ? m_ins[k][0] : 32'h0);
            chk($sformatf("pc%0d", k), 32'(opc[k]), (m_cnt[k] > 0) ? 32'(m_pcs[k][0]) : 32'h0);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_pc[0] = 8'h00;
        rst_pc[1] = 8'hFC;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'hE4121000;
        mem[1]  = 32'hE4123004;
        mem[2]  = 32'hE0433001;
        mem[11] = 32'hE4126000;
        mem[12] = 32'hE0855006;

        // Reset state
        rst = 1'b1; cyc(2);
        chk("rst_valid", 32'(valid[0]), 32'h0);
        chk("rst_level", 32'(level[0]), 32'h0);
        chk("rst_addr0", 32'(addr[0]), 32'h00);
        chk("rst_addr1", 32'(addr[1]), 32'hFC);

        // Streaming from reset, one word per cycle; DUT1 wraps 0xFC -> 0x00
        rst = 1'b0; en = 1'b1; rdy = 1'b1;
        step();
        chk("s1_pc", 32'(opc[0]), 32'h00);
        chk("s1_instr", instr[0], 32'hE4121000);
        chk("wrap_addr", 32'(addr[1]), 32'h00);
        chk("wrap_pc", 32'(opc[1]), 32'hFC);
        step();
        chk("s2_pc", 32'(opc[0]), 32'h04);
        chk("s2_instr", instr[0], 32'hE4123004);
        chk("wrap_pc2", 32'(opc[1]), 32'h00);
        step();
        chk("s3_pc", 32'(opc[0]), 32'h08);
        chk("s3_instr", instr[0], 32'hE0433001);

        // Back-pressure fills the FIFO and pins the head
        rst = 1'b1; step();
        rst = 1'b0; rdy = 1'b0; cyc(10);
        chk("bp_level", 32'(level[0]), 32'h2);
        chk("bp_addr", 32'(addr[0]), 32'h08);
        chk("bp_pc", 32'(opc[0]), 32'h00);
        rdy = 1'b1; step();
        chk("bp_next_pc", 32'(opc[0]), 32'h04);
        cyc(3);

        // Redirect while valid & ready
        br = 1'b1; tgt = 8'h2C; step();
        chk("rd_valid", 32'(valid[0]), 32'h0);
        chk("rd_addr", 32'(addr[0]), 32'h2C);
        br = 1'b0; step();
        chk("rd_pc", 32'(opc[0]), 32'h2C);
        chk("rd_instr", instr[0], 32'hE4126000);
        step();
        chk("rd_pc2", 32'(opc[0]), 32'h30);
        chk("rd_instr2", instr[0], 32'hE0855006);

        // Misaligned redirect while full
        rdy = 1'b0; cyc(3);
        chk("full_level", 32'(level[0]), 32'h2);
        br = 1'b1; tgt = 8'h2E; step();
        chk("mis_addr", 32'(addr[0]), 32'h2C);
        chk("mis_level", 32'(level[0]), 32'h0);
        br = 1'b0; cyc(3);

        // Reset while full
        chk("pre_rst_level", 32'(level[0]), 32'h2);
        rst = 1'b1; step();
        chk("mid_rst_valid", 32'(valid[0]), 32'h0);
        chk("mid_rst_addr", 32'(addr[0]), 32'h00);
        rst = 1'b0; cyc(3);

        // Disable fetch: address frozen, FIFO drains
        en = 1'b0; rdy = 1'b1; cyc(4);
        chk("dis_addr", 32'(addr[0]), 32'h08);
        chk("dis_level", 32'(level[0]), 32'h0);
        chk("dis_valid", 32'(valid[0]), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = 8'($urandom);
            en  = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
